// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared types and constants for the sequential restoring divider.
//   div_state_e      : divider control states (IDLE, BUSY, DONE)
//   ctr_width()      : width of the iteration counter for a given operand width
//   DIV_CTR_W        : iteration counter width for the default 16-bit divider
//   DBZ_QUOTIENT_ALL : all-ones pattern; the low WIDTH bits form the quotient
//                      reported for a zero divisor
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_DEFAULT_WIDTH = 16;

    // The counter has to index steps 0..WIDTH-1.
    function automatic int ctr_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DIV_CTR_W = ctr_width(DIV_DEFAULT_WIDTH);

    // Wide enough for any practical WIDTH; callers take the low WIDTH bits.
    localparam logic [255:0] DBZ_QUOTIENT_ALL = '1;

endpackage

// File: rtl/cla_sub.sv
// -----------------------------------------------------------------------------
// cla_sub
// Purely combinational N-bit subtractor computing a + ~b + 1.
// The low 4*(N/4) bits are organised as 4-bit carry-look-ahead groups, each
// producing a group generate/propagate; the group carries chain from one group
// to the next. Any bits above the last full group (one bit for N = WIDTH+1)
// extend the chain bit by bit.
//
// Ports:
//   a      in  N  minuend
//   b      in  N  subtrahend
//   diff   out N  a - b (modulo 2^N)
//   borrow out 1  set when a < b (inverse of the carry out of the top bit)
// -----------------------------------------------------------------------------
module cla_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int NG = N / 4;

    logic [N-1:0] b_inv;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic [NG:0]  gc;

    assign b_inv = ~b;
    assign g     = a & b_inv;
    assign p     = a ^ b_inv;

    // Subtraction is addition of the inverted operand with a carry-in of one.
    assign gc[0] = 1'b1;

    for (genvar j = 0; j < NG; j++) begin : g_group
        localparam int B = 4 * j;
        logic grp_g;
        logic grp_p;

        assign c[B]   = gc[j];
        assign c[B+1] = g[B]
                      | (p[B] & gc[j]);
        assign c[B+2] = g[B+1]
                      | (p[B+1] & g[B])
                      | (p[B+1] & p[B] & gc[j]);
        assign c[B+3] = g[B+2]
                      | (p[B+2] & g[B+1])
                      | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[j]);

        assign grp_g = g[B+3]
                     | (p[B+3] & g[B+2])
                     | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];

        assign gc[j+1] = grp_g | (grp_p & gc[j]);
    end

    assign c[4*NG] = gc[NG];

    // Bits beyond the last full group.
    for (genvar k = 4 * NG; k < N; k++) begin : g_tail
        assign c[k+1] = g[k] | (p[k] & c[k]);
    end

    assign diff   = p ^ c[N-1:0];
    assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// dividend consumed MSB first, trial subtraction done by cla_sub.
//
// Parameters:
//   WIDTH        operand/result width, multiple of 4, minimum 4
//
// Ports:
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous active-high reset
//   in_valid     in   1      operands present
//   in_ready     out  1      divider can accept operands (IDLE only)
//   dividend     in   WIDTH  unsigned dividend
//   divisor      in   WIDTH  unsigned divisor
//   out_valid    out  1      result present (DONE only)
//   out_ready    in   1      consumer accepts result
//   quotient     out  WIDTH  unsigned quotient
//   remainder    out  WIDTH  unsigned remainder
//   div_by_zero  out  1      result came from a zero divisor
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Operands are sampled only on that edge; later changes are
// ignored. Once out_valid rises, quotient/remainder/div_by_zero stay stable
// until the edge where out_ready is seen high, and the divider returns to
// IDLE. in_ready is low in BUSY and DONE, so no new operands can be accepted
// on the same edge that consumes a result.
// -----------------------------------------------------------------------------
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = ctr_width(WIDTH);

    div_state_e       state;
    logic [CW-1:0]    count;
    // Holds the unconsumed dividend bits at the top; quotient bits enter at
    // the bottom, so after WIDTH steps it holds the full quotient.
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] dsr_r;
    // The restored partial remainder is always below the divisor, so its
    // (WIDTH+1)-th bit is zero and is not stored.
    logic [WIDTH-1:0] rem_r;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             last_step;
    logic             unused_trial_msb;

    assign shifted = {rem_r, dvd_r[WIDTH-1]};

    cla_sub #(
        .N (WIDTH + 1)
    ) u_cla_sub (
        .a      (shifted),
        .b      ({1'b0, dsr_r}),
        .diff   (trial),
        .borrow (borrow)
    );

    // When there is no borrow the trial difference is below the divisor, so
    // its top bit carries no information beyond the borrow itself.
    assign unused_trial_msb = trial[WIDTH];

    assign rem_next  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign dvd_next  = {dvd_r[WIDTH-2:0], ~borrow};
    assign last_step = (count == CW'(WIDTH - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            dvd_r       <= '0;
            dsr_r       <= '0;
            rem_r       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_r <= dividend;
                        dsr_r <= divisor;
                        rem_r <= '0;
                        count <= '0;
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    if (dsr_r == '0) begin
                        // Zero divisor: no steps are run; the result is
                        // posted one edge after acceptance.
                        quotient    <= DBZ_QUOTIENT_ALL[WIDTH-1:0];
                        remainder   <= dvd_r;
                        div_by_zero <= 1'b1;
                        state       <= DONE;
                    end else begin
                        rem_r <= rem_next;
                        dvd_r <= dvd_next;
                        count <= count + 1'b1;
                        if (last_step) begin
                            quotient    <= dvd_next;
                            remainder   <= rem_next;
                            div_by_zero <= 1'b0;
                            state       <= DONE;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (WIDTH = 16): directed table, reset
// abort sequence, and randomized operands against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 16;
    localparam int CLK_PERIOD = 10;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    always #(CLK_PERIOD / 2) clk = ~clk;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [2*W:0] exp_q[$];   // {quotient, remainder, div_by_zero}
    time last_acc = 0;
    bit  prev_normal = 1'b0;

    task automatic check(input string name, input logic [W-1:0] got,
                         input logic [W-1:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
        end
    endtask

    task automatic check_true(input string name, input bit ok,
                              input longint got, input longint req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Reference: plain integer division, with the zero-divisor convention.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] ones;
        ones = '1;
        if (b == '0) return {ones, a, 1'b1};
        return {a / b, a % b, 1'b0};
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with the divider idle; returns at a falling
    // edge one cycle after the result handshake.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W:0] expv, input int hold);
        int           k;
        longint       spacing;
        logic [2*W:0] e;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ed;
        longint       lhs;

        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check("in_ready_wait", {15'd0, in_ready}, 16'd1);
            return;
        end

        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);                       // acceptance edge E0
        if (b != '0 && prev_normal) begin
            spacing = longint'(($time - last_acc) / CLK_PERIOD);
            check_true("accept_spacing", spacing >= W + 2, spacing, W + 2);
        end
        last_acc    = $time;
        prev_normal = (b != '0);
        exp_q.push_back(expv);

        @(negedge clk);
        k = 0;
        while (!out_valid && k < 60) begin
            // Operand changes while busy must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            dividend = W'($urandom);
            divisor  = W'($urandom);
            @(negedge clk);
            k++;
        end
        if (!out_valid) begin
            check("out_valid_wait", {15'd0, out_valid}, 16'd1);
            void'(exp_q.pop_front());
            in_valid = 1'b0;
            return;
        end
        check("latency", W'(k), (b == '0) ? W'(1) : W'(W));

        e = exp_q.pop_front();
        {eq, er, ed} = e;

        // Backpressure: result must hold and no operands may be taken.
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            check("hold_quotient", quotient, eq);
            check("hold_remainder", remainder, er);
            check("hold_in_ready", {15'd0, in_ready}, 16'd0);
            check("hold_out_valid", {15'd0, out_valid}, 16'd1);
            @(negedge clk);
        end

        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", {15'd0, div_by_zero}, {15'd0, ed});
        lhs = longint'(quotient) * longint'(b) + longint'(remainder);
        check_true("inv_q_times_d_plus_r", lhs == longint'(a), lhs, longint'(a));
        if (b != '0)
            check_true("inv_r_lt_d", remainder < b, longint'(remainder), longint'(b));

        // Offer operands on the consuming edge: they must not be taken.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_after_handshake", {15'd0, in_ready}, 16'd1);
        check("out_valid_dropped", {15'd0, out_valid}, 16'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           hold;
    } vec_t;

    vec_t tbl[11];

    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           sel;

        tbl[0]  = '{16'd100,    16'd7,      16'd14,     16'd2,      1'b0, 10};
        tbl[1]  = '{16'hFFFF,   16'd1,      16'hFFFF,   16'd0,      1'b0, 0};
        tbl[2]  = '{16'd5,      16'd9,      16'd0,      16'd5,      1'b0, 0};
        tbl[3]  = '{16'hFFFF,   16'hFFFF,   16'd1,      16'd0,      1'b0, 0};
        tbl[4]  = '{16'd1234,   16'd0,      16'hFFFF,   16'd1234,   1'b1, 2};
        tbl[5]  = '{16'd0,      16'd5,      16'd0,      16'd0,      1'b0, 0};
        tbl[6]  = '{16'd0,      16'd0,      16'hFFFF,   16'd0,      1'b1, 0};
        tbl[7]  = '{16'h8000,   16'd2,      16'h4000,   16'd0,      1'b0, 1};
        tbl[8]  = '{16'd7,      16'd7,      16'd1,      16'd0,      1'b0, 0};
        tbl[9]  = '{16'hFFFE,   16'hFFFF,   16'd0,      16'hFFFE,   1'b0, 0};
        tbl[10] = '{16'd50000,  16'd3,      16'd16666,  16'd2,      1'b0, 0};

        // Reset values.
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_quotient", quotient, 16'd0);
        check("rst_remainder", remainder, 16'd0);
        check("rst_div_by_zero", {15'd0, div_by_zero}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            do_div(tbl[i].a, tbl[i].b, {tbl[i].q, tbl[i].r, tbl[i].dbz}, tbl[i].hold);
        end

        // Reset in the middle of 50000/3, after step 8.
        in_valid = 1'b1;
        dividend = 16'd50000;
        divisor  = 16'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
        check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
        check("midrst_quotient", quotient, 16'd0);
        check("midrst_remainder", remainder, 16'd0);
        check("midrst_div_by_zero", {15'd0, div_by_zero}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_normal = 1'b0;
        @(negedge clk);
        do_div(16'd50000, 16'd3, {16'd16666, 16'd2, 1'b0}, 0);

        // Randomized operands against the reference.
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 9));
            a   = W'($urandom);
            case (sel)
                0: b = 16'd1;
                1, 2: begin
                    a = W'($urandom_range(0, 65534));
                    b = W'($urandom_range(int'(a) + 1, 65535));
                end
                3: b = 16'd0;
                4: b = W'($urandom_range(1, 255));
                default: b = W'($urandom);
            endcase
            do_div(a, b, ref_div(a, b), int'($urandom_range(0, 3)));
        end

        check_true("scoreboard_empty", exp_q.size() == 0, exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
